// File: rtl/mmio_responder.sv
// Memory-mapped peripheral: LED/switch registers, 16-bit timer with compare, sticky flags and irq.
// Define MMIO_DEBOUNCE_EN to insert a DB_CYCLES stability filter on the synchronized switches.
module mmio_responder #(
  parameter int         DB_CYCLES = 16,
  parameter logic [7:0] BASE      = 8'hF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  addr,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        hit,
  input  logic [7:0]  sw,
  output logic [7:0]  led,
  output logic        irq
);

  logic [7:0]  led_q, led_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [15:0] tcmp_q, tcmp_d;
  logic [1:0]  stat_q, stat_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        hit_q;
  logic [7:0]  sync1_q, sync2_q;

  logic [7:0]  off;
  logic        in_range;
  logic        match_set;
  logic [7:0]  sw_acc;
  logic        sw_chg;

  // Modular offset keeps the decode correct even if the window wraps past 8'hFF.
  assign off      = addr - BASE;
  assign in_range = (off < 8'd6);

`ifdef MMIO_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [7:0]    cand_q, acc_q, acc_d;

  // cand_q tracks the last synchronized value; any change reloads the down-counter.
  assign sw_chg = (sync2_q == cand_q) && (cand_q != acc_q) && (db_cnt_q == '0);
  assign sw_acc = acc_q;

  always_comb begin
    db_cnt_d = db_cnt_q;
    acc_d    = acc_q;
    if (sync2_q != cand_q) begin
      db_cnt_d = CW'(DB_CYCLES - 1);
    end else if (cand_q != acc_q) begin
      if (db_cnt_q == '0) acc_d = cand_q;
      else                db_cnt_d = db_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_q <= '0;
      cand_q   <= '0;
      acc_q    <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
      cand_q   <= sync2_q;
      acc_q    <= acc_d;
    end
  end
`else
  logic [31:0] db_unused;
  assign db_unused = 32'(DB_CYCLES);
  assign sw_acc    = sync2_q;
  assign sw_chg    = (sync1_q != sync2_q);
`endif

  always_comb begin
    led_d     = led_q;
    tcmp_d    = tcmp_q;
    ctrl_d    = ctrl_q;
    tcnt_d    = tcnt_q;
    match_set = 1'b0;
    if (ctrl_q[0]) begin
      if (tcnt_q == tcmp_q) begin
        match_set = 1'b1;
        tcnt_d    = ctrl_q[1] ? 16'h0000 : tcnt_q + 16'd1;
      end else begin
        tcnt_d = tcnt_q + 16'd1;
      end
    end
    stat_d = stat_q;
    if (wr_en && in_range) begin
      case (off[2:0])
        3'd0:    led_d  = wr_data[7:0];
        3'd2:    tcnt_d = wr_data;
        3'd3:    tcmp_d = wr_data;
        3'd4:    stat_d = stat_q & ~wr_data[1:0];
        3'd5:    ctrl_d = wr_data[3:0];
        default: ;
      endcase
    end
    // Set after clear so a same-edge event survives a W1C.
    stat_d = stat_d | {sw_chg, match_set};

    rd_data_d = 16'h0000;
    if (in_range) begin
      case (off[2:0])
        3'd0:    rd_data_d = {8'h00, led_q};
        3'd1:    rd_data_d = {8'h00, sw_acc};
        3'd2:    rd_data_d = tcnt_q;
        3'd3:    rd_data_d = tcmp_q;
        3'd4:    rd_data_d = {14'h0000, stat_q};
        3'd5:    rd_data_d = {12'h000, ctrl_q};
        default: rd_data_d = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= '0;
      tcnt_q    <= '0;
      tcmp_q    <= 16'hFFFF;
      stat_q    <= '0;
      ctrl_q    <= '0;
      rd_data_q <= '0;
      hit_q     <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
    end else begin
      led_q     <= led_d;
      tcnt_q    <= tcnt_d;
      tcmp_q    <= tcmp_d;
      stat_q    <= stat_d;
      ctrl_q    <= ctrl_d;
      rd_data_q <= rd_data_d;
      hit_q     <= in_range;
      sync1_q   <= sw;
      sync2_q   <= sync1_q;
    end
  end

  assign led     = led_q;
  assign rd_data = rd_data_q;
  assign hit     = hit_q;
  assign irq     = (stat_q[0] & ctrl_q[2]) | (stat_q[1] & ctrl_q[3]);

endmodule

// File: tb/tb_mmio_responder.sv
// Directed self-checking bench for mmio_responder (default parameters, either debounce build).
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  addr;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        hit;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic        irq;

  int checks = 0;
  int errors = 0;

  mmio_responder dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .hit     (hit),
    .sw      (sw),
    .led     (led),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    addr    = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] d, output logic h);
    addr  = a;
    wr_en = 1'b0;
    tick();
    d = rd_data;
    h = hit;
  endtask

  logic [15:0] d;
  logic        h;
  logic [15:0] cnt_exp [5];
  logic        irq_exp [5];
  logic [15:0] wrap_exp [7];
  int          n;

  initial begin
    reset   = 1'b1;
    addr    = 8'h00;
    wr_en   = 1'b0;
    wr_data = 16'h0000;
    sw      = 8'h00;
    tick();
    tick();
    chk("reset_rd_data", rd_data, 16'h0000);
    chk("reset_hit", {15'd0, hit}, 16'h0000);
    chk("reset_led", {8'd0, led}, 16'h0000);
    chk("reset_irq", {15'd0, irq}, 16'h0000);
    reset = 1'b0;

    rd(8'hF3, d, h); chk("reset_tcmp", d, 16'hFFFF); chk("tcmp_hit", {15'd0, h}, 16'h0001);
    rd(8'hF5, d, h); chk("reset_ctrl", d, 16'h0000);
    rd(8'hF2, d, h); chk("reset_tcnt", d, 16'h0000);

    wr(8'hF0, 16'h00A5);
    chk("led_after_wr", {8'd0, led}, 16'h00A5);
    rd(8'hF0, d, h); chk("led_rd", d, 16'h00A5); chk("led_hit", {15'd0, h}, 16'h0001);
    wr(8'hF0, 16'h1234);
    rd(8'hF0, d, h); chk("led_upper_bits", d, 16'h0034);
    wr(8'hF0, 16'h0055);
    chk("same_cycle_rd_old", rd_data, 16'h0034);
    chk("led_new", {8'd0, led}, 16'h0055);

    rd(8'h10, d, h); chk("oor_rd", d, 16'h0000); chk("oor_hit", {15'd0, h}, 16'h0000);
    wr(8'h10, 16'hFFFF);
    rd(8'hF0, d, h); chk("oor_wr_ignored", d, 16'h0055);
    rd(8'hF6, d, h); chk("above_top_hit", {15'd0, h}, 16'h0000);
    rd(8'hEF, d, h); chk("below_base_hit", {15'd0, h}, 16'h0000);
    rd(8'hF5, d, h); chk("top_hit", {15'd0, h}, 16'h0001);
    rd(8'hF1, d, h); chk("sw_reset_val", d, 16'h0000);

    // Timer with reload: 0,1,2,3,0 and MATCH on the 3->0 edge.
    cnt_exp = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
    irq_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    wr(8'hF3, 16'h0003);
    wr(8'hF5, 16'h0007);
    addr = 8'hF2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("tcnt_seq%0d", i), rd_data, cnt_exp[i]);
      chk($sformatf("irq_seq%0d", i), {15'd0, irq}, {15'd0, irq_exp[i]});
    end
    wr(8'hF4, 16'h0001);
    chk("w1c_irq", {15'd0, irq}, 16'h0000);
    rd(8'hF4, d, h); chk("w1c_stat", d, 16'h0000);
    wr(8'hF5, 16'h0004);
    chk("match_before_disable", {15'd0, irq}, 16'h0001);
    rd(8'hF2, d, h); chk("tcnt_reload", d, 16'h0000);
    rd(8'hF2, d, h); chk("tcnt_hold", d, 16'h0000);
    wr(8'hF4, 16'h0001);
    wr(8'hF2, 16'h0003);
    rd(8'hF4, d, h);
    rd(8'hF4, d, h); chk("no_match_ten0", d, 16'h0000);
    rd(8'hF2, d, h); chk("tcnt_hold_eq", d, 16'h0003);
    wr(8'hF5, 16'h0007);
    wr(8'hF4, 16'h0001);
    chk("set_wins_irq", {15'd0, irq}, 16'h0001);
    rd(8'hF4, d, h); chk("set_wins_stat", d, 16'h0001);

    wr(8'hF2, 16'h0005);
    rd(8'hF2, d, h); chk("wr_overrides_inc", d, 16'h0005);

    // Wrap and no-reload pass-through of the compare value.
    wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    wr(8'hF5, 16'h0001);
    wr(8'hF4, 16'h0001);
    wr(8'hF2, 16'hFFFE);
    addr = 8'hF2;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("wrap_seq%0d", i), rd_data, wrap_exp[i]);
    end
    chk("irq_masked", {15'd0, irq}, 16'h0000);
    rd(8'hF4, d, h); chk("match_no_reload", d, 16'h0001);

    wr(8'hF5, 16'h0008);
    wr(8'hF4, 16'h0003);
    chk("sw_irq_clear", {15'd0, irq}, 16'h0000);
`ifdef MMIO_DEBOUNCE_EN
    sw = 8'h01;
    repeat (5) tick();
    sw = 8'h00;
    repeat (30) tick();
    chk("glitch_irq", {15'd0, irq}, 16'h0000);
    rd(8'hF1, d, h); chk("glitch_sw", d, 16'h0000);
    rd(8'hF4, d, h); chk("glitch_swchg", d, 16'h0000);
    sw = 8'h01;
    n = 0;
    while (irq !== 1'b1 && n < 25) begin
      tick();
      n++;
    end
    chk("debounce_latency", {15'd0, (n >= 17 && n <= 19)}, 16'h0001);
    rd(8'hF1, d, h); chk("sw_accepted", d, 16'h0001);
    rd(8'hF4, d, h); chk("swchg_set", d, 16'h0002);
`else
    sw = 8'h5A;
    tick();
    chk("sw_sync_stage1", {15'd0, irq}, 16'h0000);
    tick();
    chk("sw_sync_stage2", {15'd0, irq}, 16'h0001);
    rd(8'hF1, d, h); chk("sw_accepted", d, 16'h005A);
    rd(8'hF4, d, h); chk("swchg_set", d, 16'h0002);
`endif
    wr(8'hF4, 16'h0002);
    chk("swchg_w1c", {15'd0, irq}, 16'h0000);

    // Reset in the middle of a timer run, with a competing write.
    wr(8'hF0, 16'h00FF);
    wr(8'hF3, 16'h0002);
    wr(8'hF2, 16'h0000);
    wr(8'hF5, 16'h0007);
    repeat (4) tick();
    chk("pre_reset_irq", {15'd0, irq}, 16'h0001);
    sw      = 8'h00;
    reset   = 1'b1;
    addr    = 8'hF0;
    wr_data = 16'h0077;
    wr_en   = 1'b1;
    tick();
    reset = 1'b0;
    wr_en = 1'b0;
    chk("rst_led", {8'd0, led}, 16'h0000);
    chk("rst_irq", {15'd0, irq}, 16'h0000);
    chk("rst_rd_data", rd_data, 16'h0000);
    chk("rst_hit", {15'd0, hit}, 16'h0000);
    rd(8'hF2, d, h); chk("rst_tcnt", d, 16'h0000);
    rd(8'hF3, d, h); chk("rst_tcmp", d, 16'hFFFF);
    rd(8'hF5, d, h); chk("rst_ctrl", d, 16'h0000);
    rd(8'hF1, d, h); chk("rst_sw", d, 16'h0000);
    rd(8'hF4, d, h); chk("rst_stat", d, 16'h0000);
    rd(8'hF0, d, h); chk("rst_led_rd", d, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
